// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the CSR / trap controller.
//   - Machine-mode CSR addresses used by the trap sequencer.
//   - mstatus field positions (MIE, MPIE, MPP).
//   - Sequencer state encoding.
//   - Trap cause codes.
package csr_trap_ctrl_pkg;

  // CSR addresses
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  // mstatus bit positions
  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  // Cause codes; the interrupt flag (MSB) is added by the user of CauseTimerIrq
  localparam int unsigned CauseEcallM   = 11;
  localparam int unsigned CauseTimerIrq = 7;

  typedef enum logic [2:0] {
    StIdle,
    StMcause,
    StMstatus,
    StJump,
    StRetJump
  } state_e;

endpackage

// File: rtl/csr_trap_ctrl_alu.sv
// Zicsr new-value computation.
// Ports:
//   funct3_i    Zicsr funct3 (bit 2 selects immediate source, bits 1:0 select RW/RS/RC)
//   rs1_idx_i   rs1 index, used as zimm for immediate forms and for write suppression
//   rs1_data_i  rs1 register value
//   old_i       current CSR value
//   new_o       value to write back to the CSR
//   wen_o       CSR write enable (0 for set/clear with rs1/zimm == 0)
module csr_trap_ctrl_alu #(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] old_i,
  output logic [XLEN-1:0] new_o,
  output logic            wen_o
);

  logic [XLEN-1:0] src;

  always_comb begin
    src = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;
    new_o = old_i;
    wen_o = 1'b0;
    case (funct3_i[1:0])
      2'b01: begin
        new_o = src;
        wen_o = 1'b1;
      end
      2'b10: begin
        new_o = old_i | src;
        wen_o = (rs1_idx_i != 5'd0);
      end
      2'b11: begin
        new_o = old_i & ~src;
        wen_o = (rs1_idx_i != 5'd0);
      end
      // Reserved encodings never modify the CSR
      default: begin
        new_o = old_i;
        wen_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// CSR initiator and trap sequencer, located in EX beside the ALU.
// Executes Zicsr instructions in a single cycle and sequences ECALL trap entry
// and MRET return over one CSR read port and one CSR write port, stalling the
// pipeline while sequencing and finishing with a one-cycle PC redirect.
//
// Optional feature macro: CSR_TIMER_IRQ_EN adds irq_timer_i; a pending timer
// interrupt with mstatus.MIE set enters the trap sequence with an interrupt cause.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   irq_timer_i              timer interrupt request (CSR_TIMER_IRQ_EN only)
//   csr_op_i, funct3_i       Zicsr instruction valid and its funct3
//   csr_addr_i               CSR address of the instruction
//   rs1_idx_i, rs1_data_i    rs1 index (zimm for immediate forms) and value
//   ecall_i, mret_i          ECALL / MRET in EX
//   pc_i                     PC of the instruction in EX
//   csr_rdata_i              combinational read data for csr_raddr_o
//   csr_raddr_o              CSR read address
//   csr_waddr_o, csr_wdata_o CSR write address / data
//   csr_wen_o                CSR write enable, write lands on the next clk edge
//   rd_wdata_o, rd_wen_o     old CSR value for rd and its valid pulse
//   stall_o                  hold IF/ID/EX while sequencing
//   jump_en_o, jump_addr_o   one-cycle PC redirect and its target
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ECALL_CAUSE = CauseEcallM
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CSR_TIMER_IRQ_EN
  input  logic            irq_timer_i,
`endif
  input  logic            csr_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic [11:0]     csr_raddr_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_wen_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            rd_wen_o,
  output logic            stall_o,
  output logic            jump_en_o,
  output logic [XLEN-1:0] jump_addr_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_new;
  logic            alu_wen;
  logic [11:0]     idle_raddr;
  logic [XLEN-1:0] entry_mstatus;
  logic [XLEN-1:0] ret_mstatus;
  logic            irq_take;
  logic [XLEN-1:0] trap_cause;

  csr_trap_ctrl_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .funct3_i  (funct3_i),
    .rs1_idx_i (rs1_idx_i),
    .rs1_data_i(rs1_data_i),
    .old_i     (csr_rdata_i),
    .new_o     (alu_new),
    .wen_o     (alu_wen)
  );

  // In IDLE the read port serves the Zicsr op; otherwise it watches mstatus so
  // MRET and the interrupt check see MIE/MPIE in the same cycle.
  assign idle_raddr = (csr_op_i && !ecall_i && !mret_i) ? csr_addr_i : CsrMstatus;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  always_comb begin
    entry_mstatus = csr_rdata_i;
    entry_mstatus[MstatusMpie] = csr_rdata_i[MstatusMie];
    entry_mstatus[MstatusMie] = 1'b0;
    entry_mstatus[MstatusMppHi:MstatusMppLo] = 2'b11;
  end

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- U.
  always_comb begin
    ret_mstatus = csr_rdata_i;
    ret_mstatus[MstatusMie] = csr_rdata_i[MstatusMpie];
    ret_mstatus[MstatusMpie] = 1'b1;
    ret_mstatus[MstatusMppHi:MstatusMppLo] = 2'b00;
  end

`ifdef CSR_TIMER_IRQ_EN
  // Remembers whether the running trap sequence was entered by the interrupt.
  logic irq_q, irq_d;

  // MIE is only visible when the read port is looking at mstatus this cycle.
  assign irq_take = irq_timer_i & csr_rdata_i[MstatusMie] & (idle_raddr == CsrMstatus);
  assign trap_cause = irq_q ? {1'b1, (XLEN-1)'(CauseTimerIrq)} : XLEN'(ECALL_CAUSE);
`else
  assign irq_take = 1'b0;
  assign trap_cause = XLEN'(ECALL_CAUSE);
`endif

  always_comb begin
    state_d     = state_q;
    csr_raddr_o = 12'h000;
    csr_waddr_o = 12'h000;
    csr_wdata_o = '0;
    csr_wen_o   = 1'b0;
    rd_wdata_o  = '0;
    rd_wen_o    = 1'b0;
    stall_o     = 1'b0;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
`ifdef CSR_TIMER_IRQ_EN
    irq_d = irq_q;
`endif

    unique case (state_q)
      StIdle: begin
        csr_raddr_o = idle_raddr;
        if (ecall_i || (!mret_i && irq_take)) begin
          csr_waddr_o = CsrMepc;
          csr_wdata_o = pc_i;
          csr_wen_o   = 1'b1;
          stall_o     = 1'b1;
          state_d     = StMcause;
`ifdef CSR_TIMER_IRQ_EN
          irq_d = !ecall_i;
`endif
        end else if (mret_i) begin
          csr_raddr_o = CsrMstatus;
          csr_waddr_o = CsrMstatus;
          csr_wdata_o = ret_mstatus;
          csr_wen_o   = 1'b1;
          stall_o     = 1'b1;
          state_d     = StRetJump;
        end else if (csr_op_i) begin
          csr_waddr_o = csr_addr_i;
          csr_wdata_o = alu_new;
          csr_wen_o   = alu_wen;
          rd_wdata_o  = csr_rdata_i;
          rd_wen_o    = 1'b1;
        end
      end
      StMcause: begin
        csr_raddr_o = CsrMcause;
        csr_waddr_o = CsrMcause;
        csr_wdata_o = trap_cause;
        csr_wen_o   = 1'b1;
        stall_o     = 1'b1;
        state_d     = StMstatus;
      end
      StMstatus: begin
        csr_raddr_o = CsrMstatus;
        csr_waddr_o = CsrMstatus;
        csr_wdata_o = entry_mstatus;
        csr_wen_o   = 1'b1;
        stall_o     = 1'b1;
        state_d     = StJump;
      end
      StJump: begin
        csr_raddr_o = CsrMtvec;
        jump_en_o   = 1'b1;
        // Direct mode only: MODE bits are masked off the vector base
        jump_addr_o = {csr_rdata_i[XLEN-1:2], 2'b00};
        stall_o     = 1'b1;
        state_d     = StIdle;
      end
      StRetJump: begin
        csr_raddr_o = CsrMepc;
        jump_en_o   = 1'b1;
        jump_addr_o = csr_rdata_i;
        stall_o     = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset forces every output low so no write can land on the reset edge.
    if (!rst) begin
      state_d     = StIdle;
      csr_raddr_o = 12'h000;
      csr_waddr_o = 12'h000;
      csr_wdata_o = '0;
      csr_wen_o   = 1'b0;
      rd_wdata_o  = '0;
      rd_wen_o    = 1'b0;
      stall_o     = 1'b0;
      jump_en_o   = 1'b0;
      jump_addr_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
`ifdef CSR_TIMER_IRQ_EN
      irq_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CSR_TIMER_IRQ_EN
      irq_q <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl. A small CSR register file model sits on
// the DUT's read/write ports; a separate architectural reference array holds the
// CSR values the instruction semantics say should result.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_op;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [63:0] rs1_data;
  logic        ecall;
  logic        mret;
  logic [63:0] pc;
  logic [63:0] csr_rdata;
  logic [11:0] csr_raddr;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        csr_wen;
  logic [63:0] rd_wdata;
  logic        rd_wen;
  logic        stall;
  logic        jump_en;
  logic [63:0] jump_addr;
`ifdef CSR_TIMER_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;

  // Implemented CSRs: 0 mstatus, 1 mtvec, 2 mscratch, 3 mepc, 4 mcause
  logic [63:0] env_mem[5];
  logic [63:0] ref_mem[5];
  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [63:0] pre_val = 64'h0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(
    .XLEN       (64),
    .ECALL_CAUSE(11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CSR_TIMER_IRQ_EN
    .irq_timer_i(irq),
`endif
    .csr_op_i   (csr_op),
    .funct3_i   (funct3),
    .csr_addr_i (csr_addr),
    .rs1_idx_i  (rs1_idx),
    .rs1_data_i (rs1_data),
    .ecall_i    (ecall),
    .mret_i     (mret),
    .pc_i       (pc),
    .csr_rdata_i(csr_rdata),
    .csr_raddr_o(csr_raddr),
    .csr_waddr_o(csr_waddr),
    .csr_wdata_o(csr_wdata),
    .csr_wen_o  (csr_wen),
    .rd_wdata_o (rd_wdata),
    .rd_wen_o   (rd_wen),
    .stall_o    (stall),
    .jump_en_o  (jump_en),
    .jump_addr_o(jump_addr)
  );

  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h340: return 2;
      12'h341: return 3;
      12'h342: return 4;
      default: return -1;
    endcase
  endfunction

  // Register file: unimplemented addresses read 0 and drop writes
  always_comb begin
    csr_rdata = 64'h0;
    if (idx_of(csr_raddr) >= 0) csr_rdata = env_mem[3'(idx_of(csr_raddr))];
  end

  always @(posedge clk) begin
    if (pre_en) env_mem[3'(pre_idx)] <= pre_val;
    else if (csr_wen && idx_of(csr_waddr) >= 0) env_mem[3'(idx_of(csr_waddr))] <= csr_wdata;
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_idle();
    csr_op = 1'b0; funct3 = 3'b000; csr_addr = 12'h000; rs1_idx = 5'd0;
    rs1_data = 64'h0; ecall = 1'b0; mret = 1'b0; pc = 64'h0;
`ifdef CSR_TIMER_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  task automatic preload(input int k, input logic [63:0] v);
    pre_en = 1'b1; pre_idx = k; pre_val = v; ref_mem[k] = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    csr_op = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd3;
    rs1_data = rand64(); ecall = 1'b1; mret = 1'b1; pc = rand64();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({csr_wen, rd_wen, stall, jump_en} !== 4'b0000) begin
        bad++; $display("FAIL reset_flags: got %b want 0000", {csr_wen, rd_wen, stall, jump_en});
      end
      total++;
      if ((csr_wdata | rd_wdata | jump_addr) !== 64'h0 || csr_raddr !== 12'h0 || csr_waddr !== 12'h0) begin
        bad++; $display("FAIL reset_buses: got wdata=%h rd=%h jump=%h raddr=%h waddr=%h want 0",
                        csr_wdata, rd_wdata, jump_addr, csr_raddr, csr_waddr);
      end
      @(posedge clk); #1;
      ecall = (c == 0) ? 1'b0 : 1'b1;
      mret = ~mret;
    end
    set_idle();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) preload(k, 64'h0);
  endtask

  task automatic do_zicsr(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                          input logic [63:0] data);
    int k;
    logic [63:0] old, src, nv;
    logic exp_wen;
    k = idx_of(addr);
    old = (k >= 0) ? ref_mem[k] : 64'h0;
    src = f3[2] ? 64'(idx) : data;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    exp_wen = (f3[1:0] == 2'b01) || (idx != 5'd0);
    csr_op = 1'b1; funct3 = f3; csr_addr = addr; rs1_idx = idx; rs1_data = data;
    @(negedge clk);
    total++;
    if (rd_wen !== 1'b1 || rd_wdata !== old) begin
      bad++; $display("FAIL zicsr_rd a=%h f3=%b: got wen=%b data=%h want 1 %h", addr, f3, rd_wen, rd_wdata, old);
    end
    total++;
    if (stall !== 1'b0 || jump_en !== 1'b0) begin
      bad++; $display("FAIL zicsr_nostall: got stall=%b jump=%b want 0 0", stall, jump_en);
    end
    total++;
    if (csr_wen !== exp_wen) begin
      bad++; $display("FAIL zicsr_wen a=%h f3=%b idx=%0d: got %b want %b", addr, f3, idx, csr_wen, exp_wen);
    end
    if (exp_wen) begin
      total++;
      if (csr_wdata !== nv || csr_waddr !== addr) begin
        bad++; $display("FAIL zicsr_wdata a=%h f3=%b: got %h@%h want %h@%h", addr, f3, csr_wdata, csr_waddr, nv, addr);
      end
    end
    @(posedge clk); #1;
    set_idle();
    if (exp_wen && k >= 0) ref_mem[k] = nv;
    if (k >= 0) begin
      total++;
      if (env_mem[k] !== ref_mem[k]) begin
        bad++; $display("FAIL zicsr_csr a=%h: got %h want %h", addr, env_mem[k], ref_mem[k]);
      end
    end
    @(negedge clk);
    total++;
    if (rd_wen !== 1'b0 || csr_wen !== 1'b0) begin
      bad++; $display("FAIL zicsr_pulse: got rd_wen=%b csr_wen=%b want 0 0", rd_wen, csr_wen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zicsr_directed();
    preload(1, 64'h0);
    do_zicsr(3'b001, 12'h305, 5'd7, 64'h8000_0100);
    preload(0, 64'h8);
    do_zicsr(3'b010, 12'h300, 5'd0, rand64());
    do_zicsr(3'b111, 12'h300, 5'd8, rand64());
    do_zicsr(3'b001, 12'h7c0, 5'd3, rand64());
    do_zicsr(3'b110, 12'h340, 5'd0, 64'h0);
  endtask

  task automatic test_zicsr_random();
    logic [11:0] addrs[7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7c0, 12'hf14};
    logic [2:0]  f3s[6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 40; i++) begin
      do_zicsr(f3s[$urandom_range(0, 5)], addrs[$urandom_range(0, 6)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), rand64());
    end
  endtask

  // extra: 0 plain, 1 with a Zicsr op alongside, 2 with MRET alongside
  task automatic test_ecall(input logic [63:0] pc_v, input int extra);
    logic [63:0] ms, exp_ms, exp_jump, scratch;
    ms = ref_mem[0];
    exp_ms = (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | 64'h1800;
    exp_jump = ref_mem[1] & ~64'h3;
    scratch = ref_mem[2];
    ecall = 1'b1; pc = pc_v;
    if (extra == 1) begin
      csr_op = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rs1_data = ~scratch;
    end
    if (extra == 2) mret = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'(c < 4)) begin
        bad++; $display("FAIL ecall_stall c=%0d: got %b want %b", c, stall, c < 4);
      end
      total++;
      if (jump_en !== 1'(c == 3)) begin
        bad++; $display("FAIL ecall_jump_en c=%0d: got %b want %b", c, jump_en, c == 3);
      end
      if (c == 3) begin
        total++;
        if (jump_addr !== exp_jump) begin
          bad++; $display("FAIL ecall_jump_addr: got %h want %h", jump_addr, exp_jump);
        end
      end
      total++;
      if (rd_wen !== 1'b0 || csr_wen !== 1'(c < 3)) begin
        bad++; $display("FAIL ecall_wen c=%0d: got rd=%b csr=%b want 0 %b", c, rd_wen, csr_wen, c < 3);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        ecall = 1'b0; mret = 1'b0; pc = rand64();
      end
      if (c == 3) set_idle();
    end
    ref_mem[3] = pc_v; ref_mem[4] = 64'd11; ref_mem[0] = exp_ms;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (env_mem[k] !== ref_mem[k]) begin
        bad++; $display("FAIL ecall_csr%0d: got %h want %h", k, env_mem[k], ref_mem[k]);
      end
    end
  endtask

  task automatic test_mret();
    logic [63:0] ms, exp_ms, ep;
    ms = ref_mem[0];
    ep = ref_mem[3];
    exp_ms = (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
    mret = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'(c < 2) || csr_wen !== 1'(c == 0)) begin
        bad++; $display("FAIL mret_stall c=%0d: got stall=%b wen=%b want %b %b", c, stall, csr_wen, c < 2, c == 0);
      end
      total++;
      if (jump_en !== 1'(c == 1)) begin
        bad++; $display("FAIL mret_jump_en c=%0d: got %b want %b", c, jump_en, c == 1);
      end
      if (c == 1) begin
        total++;
        if (jump_addr !== ep) begin
          bad++; $display("FAIL mret_jump_addr: got %h want %h", jump_addr, ep);
        end
      end
      @(posedge clk); #1;
      if (c == 0) mret = 1'b0;
    end
    ref_mem[0] = exp_ms;
    total++;
    if (env_mem[0] !== ref_mem[0]) begin
      bad++; $display("FAIL mret_mstatus: got %h want %h", env_mem[0], ref_mem[0]);
    end
  endtask

  task automatic test_trap_directed();
    preload(0, 64'h8);
    preload(1, 64'h8000_0103);
    test_ecall(64'h8000_0040, 0);
    preload(3, 64'h8000_0044);
    test_mret();
    test_ecall(64'h8000_0200, 1);
    test_ecall(64'h8000_0300, 2);
  endtask

  task automatic test_trap_random();
    for (int i = 0; i < 6; i++) begin
      preload(0, rand64());
      preload(1, rand64());
      test_ecall(rand64(), $urandom_range(0, 2));
      preload(0, rand64());
      preload(3, rand64());
      test_mret();
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] pv;
    pv = rand64();
    preload(4, 64'h55);
    ecall = 1'b1; pc = pv;
    @(negedge clk);
    @(posedge clk); #1;
    ecall = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({csr_wen, rd_wen, stall, jump_en} !== 4'b0000 || csr_wdata !== 64'h0) begin
      bad++; $display("FAIL rstmid_outputs: got flags=%b wdata=%h want 0000 0",
                      {csr_wen, rd_wen, stall, jump_en}, csr_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({csr_wen, rd_wen, stall, jump_en} !== 4'b0000) begin
        bad++; $display("FAIL rstmid_idle c=%0d: got %b want 0000", c, {csr_wen, rd_wen, stall, jump_en});
      end
      @(posedge clk); #1;
    end
    ref_mem[3] = pv;
    total++;
    if (env_mem[3] !== ref_mem[3] || env_mem[4] !== ref_mem[4]) begin
      bad++; $display("FAIL rstmid_csr: got mepc=%h mcause=%h want %h %h", env_mem[3], env_mem[4],
                      ref_mem[3], ref_mem[4]);
    end
  endtask

`ifdef CSR_TIMER_IRQ_EN
  task automatic test_irq();
    logic [63:0] pv, exp_ms, exp_jump;
    pv = rand64();
    preload(0, 64'h8);
    preload(1, rand64());
    exp_ms = 64'h1880;
    exp_jump = ref_mem[1] & ~64'h3;
    irq = 1'b1; pc = pv;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'(c < 4) || jump_en !== 1'(c == 3)) begin
        bad++; $display("FAIL irq_seq c=%0d: got stall=%b jump=%b want %b %b", c, stall, jump_en, c < 4, c == 3);
      end
      if (c == 3) begin
        total++;
        if (jump_addr !== exp_jump) begin
          bad++; $display("FAIL irq_jump_addr: got %h want %h", jump_addr, exp_jump);
        end
      end
      @(posedge clk); #1;
      if (c == 0) irq = 1'b0;
    end
    ref_mem[3] = pv; ref_mem[4] = 64'h8000_0000_0000_0007; ref_mem[0] = exp_ms;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (env_mem[k] !== ref_mem[k]) begin
        bad++; $display("FAIL irq_csr%0d: got %h want %h", k, env_mem[k], ref_mem[k]);
      end
    end
    // MIE is now clear, so the request must be ignored
    irq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'b0 || csr_wen !== 1'b0) begin
        bad++; $display("FAIL irq_masked c=%0d: got stall=%b wen=%b want 0 0", c, stall, csr_wen);
      end
      @(posedge clk); #1;
    end
    irq = 1'b0;
  endtask
`endif

  initial begin
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_zicsr_directed();
    test_zicsr_random();
    test_trap_directed();
    test_trap_random();
    test_reset_mid();
`ifdef CSR_TIMER_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
